// File: rtl/qdr_dly_sweep.sv
// Per-bit IODELAY eye finder: zero the tap, scan upward against an external checker,
// record the first contiguous passing window and park the tap at its centre.
module qdr_dly_sweep #(
    parameter int unsigned NUM_IN        = 36,
    parameter int unsigned NUM_OUT       = 37,
    parameter int unsigned TAP_BITS      = 5,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CHK_TIMEOUT   = 1024
) (
    input  logic                                 dly_clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [6:0]                           sel,
    input  logic [TAP_BITS*(NUM_IN+NUM_OUT)-1:0] dly_cntrs,
    output logic                                 chk_req,
    input  logic                                 chk_done,
    input  logic                                 chk_pass,
    output logic [NUM_IN-1:0]                    dly_en_i,
    output logic [NUM_OUT-1:0]                   dly_en_o,
    output logic                                 dly_inc_dec,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 fail,
    output logic [1:0]                           err_code,
    output logic [TAP_BITS-1:0]                  win_start,
    output logic [TAP_BITS-1:0]                  win_end,
    output logic [TAP_BITS-1:0]                  final_tap
);

    localparam int unsigned SEL_W    = 7;
    localparam int unsigned NUM_BITS = NUM_IN + NUM_OUT;
    localparam int unsigned CNT_MAX  = (CHK_TIMEOUT > SETTLE_CYCLES) ? CHK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0]    SEL_LIMIT = SEL_W'(NUM_BITS);
    localparam logic [SEL_W-1:0]    SEL_IN    = SEL_W'(NUM_IN);
    localparam logic [TAP_BITS-1:0] TAP_MAX   = {TAP_BITS{1'b1}};

    localparam logic [1:0] ERR_BAD_SEL = 2'd1;
    localparam logic [1:0] ERR_NO_EYE  = 2'd2;
    localparam logic [1:0] ERR_STUCK   = 2'd3;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CHKSEL = 4'd1;
    localparam logic [3:0] S_ZERO   = 4'd2;
    localparam logic [3:0] S_DIR    = 4'd3;
    localparam logic [3:0] S_PULSE  = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_CHECK  = 4'd6;
    localparam logic [3:0] S_SCAN   = 4'd7;
    localparam logic [3:0] S_CENTRE = 4'd8;

    logic [3:0]          state, state_nxt;
    logic [3:0]          ret, ret_nxt;
    logic [SEL_W-1:0]    sel_q, sel_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [TAP_BITS-1:0] exp_tap, exp_nxt;
    logic                win_vld, win_vld_nxt;
    logic [TAP_BITS-1:0] win_start_nxt, win_end_nxt, final_tap_nxt;
    logic                busy_nxt, done_nxt, fail_nxt, chk_req_nxt, inc_dec_nxt;
    logic [1:0]          err_nxt;
    logic [NUM_IN-1:0]   en_i_nxt;
    logic [NUM_OUT-1:0]  en_o_nxt;

    logic                step_go, step_inc, fail_go;
    logic [1:0]          fail_code;
    logic [TAP_BITS-1:0] tap;
    logic [TAP_BITS:0]   win_sum;
    logic [TAP_BITS-1:0] target;

    // Current tap of the selected line, and the floor midpoint of the recorded window
    assign tap     = TAP_BITS'(dly_cntrs >> (TAP_BITS * 32'(sel_q)));
    assign win_sum = {1'b0, win_start} + {1'b0, win_end};
    assign target  = win_sum[TAP_BITS:1];

    always_ff @(posedge dly_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ret         <= S_IDLE;
            sel_q       <= '0;
            cnt         <= '0;
            exp_tap     <= '0;
            win_vld     <= 1'b0;
            win_start   <= '0;
            win_end     <= '0;
            final_tap   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            err_code    <= '0;
            chk_req     <= 1'b0;
            dly_inc_dec <= 1'b0;
            dly_en_i    <= '0;
            dly_en_o    <= '0;
        end else begin
            state       <= state_nxt;
            ret         <= ret_nxt;
            sel_q       <= sel_nxt;
            cnt         <= cnt_nxt;
            exp_tap     <= exp_nxt;
            win_vld     <= win_vld_nxt;
            win_start   <= win_start_nxt;
            win_end     <= win_end_nxt;
            final_tap   <= final_tap_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            fail        <= fail_nxt;
            err_code    <= err_nxt;
            chk_req     <= chk_req_nxt;
            dly_inc_dec <= inc_dec_nxt;
            dly_en_i    <= en_i_nxt;
            dly_en_o    <= en_o_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ret_nxt       = ret;
        sel_nxt       = sel_q;
        cnt_nxt       = cnt;
        exp_nxt       = exp_tap;
        win_vld_nxt   = win_vld;
        win_start_nxt = win_start;
        win_end_nxt   = win_end;
        final_tap_nxt = final_tap;
        busy_nxt      = busy;
        done_nxt      = done;
        fail_nxt      = fail;
        err_nxt       = err_code;
        chk_req_nxt   = chk_req;
        inc_dec_nxt   = dly_inc_dec;
        en_i_nxt      = '0;
        en_o_nxt      = '0;
        step_go       = 1'b0;
        step_inc      = 1'b0;
        fail_go       = 1'b0;
        fail_code     = 2'd0;

        if (abort && state != S_IDLE) begin
            state_nxt   = S_IDLE;
            busy_nxt    = 1'b0;
            chk_req_nxt = 1'b0;
            inc_dec_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        sel_nxt       = sel;
                        busy_nxt      = 1'b1;
                        done_nxt      = 1'b0;
                        fail_nxt      = 1'b0;
                        err_nxt       = 2'd0;
                        win_vld_nxt   = 1'b0;
                        win_start_nxt = '0;
                        win_end_nxt   = '0;
                        final_tap_nxt = '0;
                        state_nxt     = S_CHKSEL;
                    end
                end
                S_CHKSEL: begin
                    if (sel_q >= SEL_LIMIT) begin
                        fail_go   = 1'b1;
                        fail_code = ERR_BAD_SEL;
                    end else begin
                        state_nxt = S_ZERO;
                    end
                end
                S_ZERO: begin
                    if (tap != '0) begin
                        step_go = 1'b1;
                        ret_nxt = S_ZERO;
                    end else begin
                        state_nxt   = S_SCAN;
                        chk_req_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end
                end
                S_DIR: begin
                    if (sel_q < SEL_IN) begin
                        en_i_nxt = NUM_IN'(1) << sel_q;
                    end else begin
                        en_o_nxt = NUM_OUT'(1) << (sel_q - SEL_IN);
                    end
                    state_nxt = S_PULSE;
                end
                S_PULSE: begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_nxt = S_CHECK;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (tap != exp_tap) begin
                        fail_go   = 1'b1;
                        fail_code = ERR_STUCK;
                    end else begin
                        state_nxt = ret;
                        if (ret == S_SCAN) begin
                            chk_req_nxt = 1'b1;
                            cnt_nxt     = '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (chk_done) begin
                        chk_req_nxt = 1'b0;
                        if (chk_pass) begin
                            if (!win_vld) begin
                                win_start_nxt = tap;
                            end
                            win_vld_nxt = 1'b1;
                            win_end_nxt = tap;
                        end
                        // First failing tap after a pass closes the window: no further scanning
                        if (!chk_pass && win_vld) begin
                            state_nxt = S_CENTRE;
                        end else if (tap != TAP_MAX) begin
                            step_go  = 1'b1;
                            step_inc = 1'b1;
                            ret_nxt  = S_SCAN;
                        end else if (chk_pass || win_vld) begin
                            state_nxt = S_CENTRE;
                        end else begin
                            fail_go       = 1'b1;
                            fail_code     = ERR_NO_EYE;
                            final_tap_nxt = tap;
                        end
                    end else if (cnt == CNT_W'(CHK_TIMEOUT - 1)) begin
                        fail_go   = 1'b1;
                        fail_code = ERR_STUCK;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_CENTRE: begin
                    if (tap > target) begin
                        step_go = 1'b1;
                        ret_nxt = S_CENTRE;
                    end else if (tap < target) begin
                        step_go  = 1'b1;
                        step_inc = 1'b1;
                        ret_nxt  = S_CENTRE;
                    end else begin
                        final_tap_nxt = target;
                        done_nxt      = 1'b1;
                        busy_nxt      = 1'b0;
                        state_nxt     = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            if (step_go) begin
                state_nxt   = S_DIR;
                inc_dec_nxt = step_inc;
                exp_nxt     = step_inc ? tap + TAP_BITS'(1) : tap - TAP_BITS'(1);
            end

            if (fail_go) begin
                state_nxt   = S_IDLE;
                fail_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                err_nxt     = fail_code;
                chk_req_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qdr_dly_sweep.sv
// Directed bench for qdr_dly_sweep: behavioural tap model, pass/fail checker responder
// and a queue of expected sweep outcomes compared when each sweep ends.
module tb_qdr_dly_sweep;

    localparam int NUM_IN  = 36;
    localparam int NUM_OUT = 37;
    localparam int TBW     = 5;
    localparam int NB      = NUM_IN + NUM_OUT;

    logic              dly_clk = 1'b0;
    logic              rst, start, abort;
    logic [6:0]        sel;
    logic [TBW*NB-1:0] dly_cntrs;
    logic              chk_req, chk_done, chk_pass;
    logic [NUM_IN-1:0] dly_en_i;
    logic [NUM_OUT-1:0] dly_en_o;
    logic              dly_inc_dec, busy, done, fail;
    logic [1:0]        err_code;
    logic [TBW-1:0]    win_start, win_end, final_tap;

    typedef struct {
        int done;
        int fail;
        int err;
        int ws;
        int we;
        int ft;
        int inc;
        int dec;
        int bad;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    int  tap_m [NB];
    int  n_inc = 0, n_dec = 0, n_bad = 0, n_req = 0;
    int  mon_sel, tap_load_idx, tap_load_val;
    bit  tap_load, stuck, resp_en;
    int  resp_wait, resp_lat;
    logic [31:0]   pass_mask;
    logic [NB-1:0] en_all;

    qdr_dly_sweep dut (
        .dly_clk     (dly_clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .sel         (sel),
        .dly_cntrs   (dly_cntrs),
        .chk_req     (chk_req),
        .chk_done    (chk_done),
        .chk_pass    (chk_pass),
        .dly_en_i    (dly_en_i),
        .dly_en_o    (dly_en_o),
        .dly_inc_dec (dly_inc_dec),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .err_code    (err_code),
        .win_start   (win_start),
        .win_end     (win_end),
        .final_tap   (final_tap)
    );

    always #5 dly_clk = ~dly_clk;

    assign en_all = {dly_en_o, dly_en_i};

    always_comb begin
        for (int k = 0; k < NB; k++) dly_cntrs[TBW*k +: TBW] = TBW'(tap_m[k]);
    end

    // Tap model: a delay line moves one tap on each clock edge that sees its enable high
    always @(posedge dly_clk) begin
        if (en_all[mon_sel]) begin
            if (dly_inc_dec) n_inc <= n_inc + 1;
            else             n_dec <= n_dec + 1;
        end
        n_bad <= n_bad + $countones(en_all) - int'(en_all[mon_sel]);
        if (chk_req) n_req <= n_req + 1;
        if (tap_load) begin
            tap_m[tap_load_idx] <= tap_load_val;
        end else if (!stuck) begin
            for (int k = 0; k < NB; k++) begin
                if (en_all[k]) begin
                    if (dly_inc_dec && tap_m[k] < 31)       tap_m[k] <= tap_m[k] + 1;
                    else if (!dly_inc_dec && tap_m[k] > 0)  tap_m[k] <= tap_m[k] - 1;
                end
            end
        end
    end

    // Checker responder: answers a raised chk_req after a short random latency
    initial begin
        chk_done  = 1'b0;
        chk_pass  = 1'b0;
        resp_wait = 0;
        resp_lat  = 1;
        forever begin
            @(negedge dly_clk);
            if (chk_done) begin
                chk_done = 1'b0;
                chk_pass = 1'b0;
            end else if (chk_req && resp_en) begin
                if (resp_wait < resp_lat) begin
                    resp_wait++;
                end else begin
                    chk_done  = 1'b1;
                    chk_pass  = pass_mask[tap_m[mon_sel]];
                    resp_wait = 0;
                    resp_lat  = int'($urandom_range(0, 3));
                end
            end
        end
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},      int'(busy), 0);
        check({tag, " done"},      int'(done), 0);
        check({tag, " fail"},      int'(fail), 0);
        check({tag, " err_code"},  int'(err_code), 0);
        check({tag, " chk_req"},   int'(chk_req), 0);
        check({tag, " en"},        int'(en_all != '0), 0);
        check({tag, " inc_dec"},   int'(dly_inc_dec), 0);
        check({tag, " win_start"}, int'(win_start), 0);
        check({tag, " win_end"},   int'(win_end), 0);
        check({tag, " final_tap"}, int'(final_tap), 0);
    endtask

    task automatic set_tap(input int idx, input int v);
        tap_load_idx = idx;
        tap_load_val = v;
        tap_load     = 1'b1;
        @(negedge dly_clk);
        tap_load     = 1'b0;
    endtask

    task automatic run_test(input string name, input int s, input int tap0,
                            input logic [31:0] mask, input bit inject, input exp_t e);
        int   i0, d0, b0;
        bit   to;
        exp_t g;
        mon_sel   = s;
        set_tap(s, tap0);
        pass_mask = mask;
        sb.push_back(e);
        i0 = n_inc;
        d0 = n_dec;
        b0 = n_bad;
        sel   = 7'(s);
        start = 1'b1;
        @(negedge dly_clk);
        start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            if (inject && c == 100) begin
                sel   = 7'd80;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge dly_clk);
        end
        start = 1'b0;
        check({name, " timeout"}, int'(to), 0);
        g = sb.pop_front();
        check({name, " done"},      int'(done), g.done);
        check({name, " fail"},      int'(fail), g.fail);
        check({name, " err_code"},  int'(err_code), g.err);
        check({name, " win_start"}, int'(win_start), g.ws);
        check({name, " win_end"},   int'(win_end), g.we);
        check({name, " final_tap"}, int'(final_tap), g.ft);
        check({name, " inc pulses"}, n_inc - i0, g.inc);
        check({name, " dec pulses"}, n_dec - d0, g.dec);
        check({name, " stray pulses"}, n_bad - b0, g.bad);
    endtask

    initial begin
        int i0, d0, b0, r0;
        bit hit;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = '0;
        resp_en = 1'b1; stuck = 1'b0; pass_mask = '0;
        tap_load = 1'b0; tap_load_idx = 0; tap_load_val = 0; mon_sel = 0;
        repeat (3) @(negedge dly_clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge dly_clk);

        // Eye at taps 10..20, starting from tap 7
        run_test("A", 3, 7, 32'h001F_FC00, 1'b0,
                 '{done:1, fail:0, err:0, ws:10, we:20, ft:15, inc:21, dec:13, bad:0});
        check("A model tap", tap_m[3], 15);

        // Output-side line with no eye at all
        run_test("B", 40, 0, 32'h0, 1'b0,
                 '{done:0, fail:1, err:2, ws:0, we:0, ft:31, inc:31, dec:0, bad:0});
        check("B model tap", tap_m[40], 31);

        // Out-of-range bit index
        mon_sel = 0;
        i0 = n_inc; d0 = n_dec; b0 = n_bad; r0 = n_req;
        sel = 7'd80; start = 1'b1;
        @(negedge dly_clk);
        start = 1'b0;
        check("C busy", int'(busy), 1);
        check("C fail early", int'(fail), 0);
        @(negedge dly_clk);
        check("C fail", int'(fail), 1);
        check("C err_code", int'(err_code), 1);
        check("C busy end", int'(busy), 0);
        repeat (30) @(negedge dly_clk);
        check("C pulses", (n_inc - i0) + (n_dec - d0) + (n_bad - b0), 0);
        check("C chk_req cycles", n_req - r0, 0);

        // Delay line ignores pulses
        stuck = 1'b1;
        run_test("D", 5, 5, 32'hFFFF_FFFF, 1'b0,
                 '{done:0, fail:1, err:3, ws:0, we:0, ft:0, inc:0, dec:1, bad:0});
        stuck = 1'b0;
        check("D model tap", tap_m[5], 5);

        // Checker never answers
        resp_en = 1'b0;
        r0 = n_req;
        run_test("E", 2, 0, 32'h0, 1'b0,
                 '{done:0, fail:1, err:3, ws:0, we:0, ft:0, inc:0, dec:0, bad:0});
        check("E chk_req cycles", n_req - r0, 1024);
        check("E chk_req low", int'(chk_req), 0);
        resp_en = 1'b1;

        // Single-tap eye at TAP_MAX, with a stray start mid-sweep
        run_test("F", 50, 0, 32'h8000_0000, 1'b1,
                 '{done:1, fail:0, err:0, ws:31, we:31, ft:31, inc:31, dec:0, bad:0});
        check("F model tap", tap_m[50], 31);

        // Abort during the scan
        mon_sel   = 1;
        set_tap(1, 0);
        pass_mask = 32'h001F_FC00;
        i0 = n_inc;
        sel = 7'd1; start = 1'b1;
        @(negedge dly_clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ((n_inc - i0) >= 5 && chk_req) begin
                hit = 1'b1;
                break;
            end
            @(negedge dly_clk);
        end
        check("G reached scan", int'(hit), 1);
        abort = 1'b1;
        @(negedge dly_clk);
        abort = 1'b0;
        check_zero("G abort");
        i0 = n_inc; d0 = n_dec; b0 = n_bad; r0 = n_req;
        repeat (60) @(negedge dly_clk);
        check("G pulses after abort", (n_inc - i0) + (n_dec - d0) + (n_bad - b0), 0);
        check("G chk_req after abort", n_req - r0, 0);
        check("G busy after abort", int'(busy), 0);

        // Start and abort together in IDLE
        sel = 7'd3; start = 1'b1; abort = 1'b1;
        @(negedge dly_clk);
        start = 1'b0; abort = 1'b0;
        check("H busy", int'(busy), 0);
        repeat (5) @(negedge dly_clk);
        check("H busy later", int'(busy), 0);

        // Asynchronous reset while an enable pulse is high
        mon_sel = 0;
        set_tap(0, 3);
        sel = 7'd0; start = 1'b1;
        @(negedge dly_clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (dly_en_i[0]) begin
                hit = 1'b1;
                break;
            end
            @(negedge dly_clk);
        end
        check("I pulse seen", int'(hit), 1);
        rst = 1'b1;
        #1;
        check_zero("I async reset");
        i0 = n_inc; d0 = n_dec; b0 = n_bad;
        @(negedge dly_clk);
        rst = 1'b0;
        repeat (40) @(negedge dly_clk);
        check("I pulses after reset", (n_inc - i0) + (n_dec - d0) + (n_bad - b0), 0);
        check("I model tap", tap_m[0], 3);
        check("I busy", int'(busy), 0);
        check("scoreboard empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
